rmii_phy_rx: RTL and testbench

- PHY-side receiver for the MAC transmit half of an RMII link. Samples TX_EN/TXD[1:0] from the MAC on the 50 MHz reference clock.
- Validates preamble and SFD, assembles LSB-first dibits into bytes, and emits them as a byte stream with sof/eof framing.
- Checks the Ethernet FCS on every frame.
- Used as the far-end model and loopback monitor for the EthernetRMII MAC and its RMII interface.

---
 rtl/rmii_phy_rx.sv | 133 +++++++++++++
 tb/tb_rmii_phy_rx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rmii_phy_rx.sv
// rmii_phy_rx: RMII MAC-transmit receiver that checks preamble/SFD, assembles bytes and checks the FCS
module rmii_phy_rx #(
  parameter int SPEED     = 100,
  parameter int MAX_FRAME = 1522
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       tx_en,
  input  logic [1:0] txd,
  output logic [7:0] m_data,
  output logic       m_valid,
  output logic       m_sof,
  output logic       m_eof,
  output logic       m_crc_ok,
  output logic       m_err
);
  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  state_t state, state_n;
  logic en_r, en_q, rise, sample;
  logic [1:0] d_r, phase, phase_n;
  logic [3:0] div;
  logic [4:0] pcnt, pcnt_n;
  logic [7:0] sr, sr_n, hold, hold_n, byte_w;
  logic [15:0] bcnt, bcnt_n;
  logic [31:0] crc, crc_n;
  logic valid_n, sof_n, eof_n, ok_n, err_n;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 32'hEDB88320 : 32'h0);
    return r;
  endfunction
  assign rise   = en_r && !en_q;
  assign sample = en_r && (SPEED == 10 ? div == 4'd4 : 1'b1);
  assign byte_w = {d_r, sr[7:2]};
  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    phase_n = phase;
    sr_n    = sr;
    hold_n  = hold;
    bcnt_n  = bcnt;
    crc_n   = crc;
    valid_n = 1'b0;
    sof_n   = 1'b0;
    eof_n   = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    case (state)
      IDLE: if (rise) begin
        state_n = PREAMBLE;
        pcnt_n  = '0;
      end
      PREAMBLE:
        if (!en_r) state_n = IDLE;
        else if (sample) begin
          if (d_r == 2'b01) pcnt_n = pcnt + 5'(pcnt != 5'd31);
          else if (d_r == 2'b11 && pcnt >= 5'd4) begin
            state_n = DATA;
            crc_n   = '1;
            bcnt_n  = '0;
            phase_n = '0;
          end else state_n = DROP;
        end
      DATA:
        if (!en_r) begin
          state_n = IDLE;
          valid_n = bcnt != '0;
          sof_n   = bcnt == 16'd1;
          eof_n   = bcnt != '0;
          ok_n    = bcnt != '0 && crc == RESIDUE;
          err_n   = bcnt != '0 && phase != 2'd0;
        end else if (sample) begin
          sr_n    = byte_w;
          phase_n = phase + 2'd1;
          if (phase == 2'd3) begin
            valid_n = bcnt != '0;
            sof_n   = bcnt == 16'd1;
            if (bcnt == 16'(MAX_FRAME)) begin
              eof_n   = 1'b1;
              err_n   = 1'b1;
              state_n = DROP;
            end else begin
              hold_n = byte_w;
              crc_n  = crc8(crc, byte_w);
              bcnt_n = bcnt + 16'd1;
            end
          end
        end
      default: if (!en_r) state_n = IDLE;
    endcase
  end
  // en_r/en_q reset high so a frame already in flight at release never looks like a rising edge
  always_ff @(posedge clk or posedge srst)
    if (srst) begin
      en_r     <= 1'b1;
      en_q     <= 1'b1;
      d_r      <= '0;
      div      <= '0;
      state    <= IDLE;
      pcnt     <= '0;
      phase    <= '0;
      sr       <= '0;
      hold     <= '0;
      bcnt     <= '0;
      crc      <= '1;
      m_data   <= '0;
      m_valid  <= 1'b0;
      m_sof    <= 1'b0;
      m_eof    <= 1'b0;
      m_crc_ok <= 1'b0;
      m_err    <= 1'b0;
    end else begin
      en_r     <= tx_en;
      en_q     <= en_r;
      d_r      <= txd;
      div      <= (rise || div == 4'd9) ? 4'd0 : div + 4'd1;
      state    <= state_n;
      pcnt     <= pcnt_n;
      phase    <= phase_n;
      sr       <= sr_n;
      hold     <= hold_n;
      bcnt     <= bcnt_n;
      crc      <= crc_n;
      m_data   <= hold;
      m_valid  <= valid_n;
      m_sof    <= sof_n;
      m_eof    <= eof_n;
      m_crc_ok <= ok_n;
      m_err    <= err_n;
    end
endmodule

// File: tb/tb_rmii_phy_rx.sv
// tb_rmii_phy_rx: directed bench for rmii_phy_rx at 100 Mb/s, 10 Mb/s and a short MAX_FRAME
module tb_rmii_phy_rx;
  logic clk = 1'b0, srst = 1'b1, tx_en = 1'b0;
  logic [1:0] txd = 2'b00;
  logic [7:0] md [3];
  logic mv [3], ms [3], me [3], mo [3], mr [3];
  int cyc = 0, n_cmp = 0, n_fail = 0;
  logic [7:0] fb [0:127];
  typedef struct packed {logic [7:0] d; logic s, e, o, r; int t;} pulse_t;
  pulse_t qa[$], qb[$], qc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (mv[0]) qa.push_back({md[0], ms[0], me[0], mo[0], mr[0], cyc});
    if (mv[1]) qb.push_back({md[1], ms[1], me[1], mo[1], mr[1], cyc});
    if (mv[2]) qc.push_back({md[2], ms[2], me[2], mo[2], mr[2], cyc});
  end

  rmii_phy_rx #(.SPEED(100), .MAX_FRAME(1522)) u_a (.clk(clk), .srst(srst), .tx_en(tx_en), .txd(txd),
    .m_data(md[0]), .m_valid(mv[0]), .m_sof(ms[0]), .m_eof(me[0]), .m_crc_ok(mo[0]), .m_err(mr[0]));
  rmii_phy_rx #(.SPEED(10), .MAX_FRAME(1522)) u_b (.clk(clk), .srst(srst), .tx_en(tx_en), .txd(txd),
    .m_data(md[1]), .m_valid(mv[1]), .m_sof(ms[1]), .m_eof(me[1]), .m_crc_ok(mo[1]), .m_err(mr[1]));
  rmii_phy_rx #(.SPEED(100), .MAX_FRAME(64)) u_c (.clk(clk), .srst(srst), .tx_en(tx_en), .txd(txd),
    .m_data(md[2]), .m_valid(mv[2]), .m_sof(ms[2]), .m_eof(me[2]), .m_crc_ok(mo[2]), .m_err(mr[2]));

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c;
    logic f;
    c = '1;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 8; k++) begin
        f = c[0] ^ fb[i][k];
        c = {1'b0, c[31:1]} ^ (f ? 32'hEDB88320 : 32'h0);
      end
    return c;
  endfunction

  task automatic fill_plain;
    for (int i = 0; i < 128; i++) fb[i] = 8'(i);
  endtask

  task automatic build_good(input bit corrupt);
    logic [31:0] f;
    fill_plain;
    f = ~crc_of(60);
    for (int k = 0; k < 4; k++) fb[60+k] = f[8*k +: 8];
    if (corrupt) fb[63] = fb[63] ^ 8'h01;
  endtask

  task automatic drive(input logic [1:0] d, input int h);
    repeat (h) begin
      @(posedge clk); #1;
      tx_en = 1'b1;
      txd = d;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int h);
    for (int k = 0; k < 4; k++) drive(b[2*k +: 2], h);
  endtask

  task automatic gap(input int n);
    @(posedge clk); #1;
    tx_en = 1'b0;
    txd = 2'b00;
    repeat (n) @(posedge clk);
  endtask

  task automatic send_frame(input int n, input int extra, input int h);
    for (int i = 0; i < 7; i++) send_byte(8'h55, h);
    send_byte(8'hD5, h);
    for (int i = 0; i < n; i++) send_byte(fb[i], h);
    for (int k = 0; k < extra; k++) drive(fb[n][2*k +: 2], h);
    gap(30);
  endtask

  task automatic test_reset;
    srst = 1'b1;
    repeat (3) @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({md[k], mv[k], ms[k], me[k], mo[k], mr[k]} !== 13'h0) begin
        n_fail++;
        $display("FAIL reset inst%0d: got %h want 0", k, {md[k], mv[k], ms[k], me[k], mo[k], mr[k]});
      end
    end
    srst = 1'b0;
    gap(5);
  endtask

  task automatic test_frame(input string nm, input bit corrupt, input bit slow);
    pulse_t q[$];
    build_good(corrupt);
    qa.delete();
    qb.delete();
    send_frame(64, 0, slow ? 10 : 1);
    if (slow) q = qb; else q = qa;
    n_cmp++;
    if (q.size() !== 64) begin
      n_fail++;
      $display("FAIL %s count: got %0d want 64", nm, q.size());
    end
    for (int i = 0; i < q.size(); i++) begin
      n_cmp++;
      if ({q[i].d, q[i].s, q[i].e} !== {fb[i], i == 0, i == 63}) begin
        n_fail++;
        $display("FAIL %s byte%0d data/sof/eof: got %h/%b/%b want %h/%b/%b", nm, i,
                 q[i].d, q[i].s, q[i].e, fb[i], i == 0, i == 63);
      end
    end
    for (int i = 1; i < 63 && i < q.size(); i++) begin
      n_cmp++;
      if (q[i].t - q[i-1].t !== (slow ? 40 : 4)) begin
        n_fail++;
        $display("FAIL %s spacing%0d: got %0d want %0d", nm, i, q[i].t - q[i-1].t, slow ? 40 : 4);
      end
    end
    n_cmp++;
    if (q.size() == 0 || {q[q.size()-1].o, q[q.size()-1].r} !== {!corrupt, 1'b0}) begin
      n_fail++;
      $display("FAIL %s crc_ok/err: got %b want %b", nm,
               q.size() == 0 ? 2'bxx : {q[q.size()-1].o, q[q.size()-1].r}, {!corrupt, 1'b0});
    end
  endtask

  task automatic test_truncated;
    fill_plain;
    qa.delete();
    send_frame(10, 2, 1);
    n_cmp++;
    if (qa.size() !== 10) begin
      n_fail++;
      $display("FAIL trunc count: got %0d want 10", qa.size());
    end
    n_cmp++;
    if (qa.size() == 0 || {qa[qa.size()-1].d, qa[qa.size()-1].e, qa[qa.size()-1].r} !== {8'd9, 2'b11}) begin
      n_fail++;
      $display("FAIL trunc last data/eof/err: got %0d pulses, want byte 09 eof=1 err=1", qa.size());
    end
    n_cmp++;
    if (qa.size() == 0 || qa[0].s !== 1'b1) begin
      n_fail++;
      $display("FAIL trunc sof: first pulse sof not 1 (pulses %0d)", qa.size());
    end
  endtask

  task automatic test_bad_preamble;
    fill_plain;
    qa.delete();
    for (int i = 0; i < 3; i++) drive(2'b01, 1);
    drive(2'b10, 1);
    for (int i = 0; i < 20; i++) send_byte(fb[i], 1);
    gap(30);
    n_cmp++;
    if (qa.size() !== 0) begin
      n_fail++;
      $display("FAIL badpre count: got %0d want 0", qa.size());
    end
    test_frame("after_badpre", 1'b0, 1'b0);
  endtask

  task automatic test_overlength;
    fill_plain;
    qc.delete();
    send_frame(70, 0, 1);
    n_cmp++;
    if (qc.size() !== 64) begin
      n_fail++;
      $display("FAIL overlen count: got %0d want 64", qc.size());
    end
    n_cmp++;
    if (qc.size() < 64 || {qc[63].d, qc[63].e, qc[63].o, qc[63].r} !== {8'd63, 3'b101}) begin
      n_fail++;
      $display("FAIL overlen last: got %0d pulses, want byte 3f eof=1 ok=0 err=1", qc.size());
    end
    n_cmp++;
    if (qc.size() < 64 || qc[62].e !== 1'b0) begin
      n_fail++;
      $display("FAIL overlen early eof: pulse 62 eof set or missing (pulses %0d)", qc.size());
    end
  endtask

  task automatic test_reset_midframe;
    int pre;
    build_good(1'b0);
    qa.delete();
    pre = 0;
    fork
      send_frame(64, 0, 1);
      begin
        repeat (112) @(posedge clk); #3;
        srst = 1'b1;
        #1;
        n_cmp++;
        if ({md[0], mv[0], ms[0], me[0], mo[0], mr[0]} !== 13'h0) begin
          n_fail++;
          $display("FAIL midrst outputs: got %h want 0", {md[0], mv[0], ms[0], me[0], mo[0], mr[0]});
        end
        pre = qa.size();
        repeat (2) @(posedge clk); #3;
        srst = 1'b0;
      end
    join
    n_cmp++;
    if (pre == 0 || qa.size() !== pre) begin
      n_fail++;
      $display("FAIL midrst pulses: got %0d total, %0d before reset (want equal and nonzero)", qa.size(), pre);
    end
    test_frame("after_rst", 1'b0, 1'b0);
  endtask

  initial begin
    test_reset;
    test_frame("good100", 1'b0, 1'b0);
    test_frame("badfcs", 1'b1, 1'b0);
    test_frame("speed10", 1'b0, 1'b1);
    test_truncated;
    test_bad_preamble;
    test_overlength;
    test_reset_midframe;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
